// File: rtl/nzp_compare_unit.sv
// Per-thread signed/unsigned compare into NZP flag registers,
// with a one-entry valid/ready output stage and branch evaluation.
module nzp_compare_unit #(
  parameter int WIDTH   = 8,
  parameter int THREADS = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     signed_mode,
  input  logic [THREADS-1:0]       thread_mask,
  input  logic [THREADS*WIDTH-1:0] rs,
  input  logic [THREADS*WIDTH-1:0] rt,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [THREADS-1:0]       out_mask,
  output logic [THREADS*3-1:0]     out_nzp,
  input  logic [2:0]               br_cond,
  output logic [THREADS-1:0]       br_taken
);

  logic                 valid_q;
  logic [THREADS-1:0]   mask_q;
  logic [THREADS*3-1:0] nzp_q;
  logic [THREADS*3-1:0] flags;
  logic                 accept;

  assign in_ready = !valid_q | out_ready;
  assign accept   = in_valid & in_ready;

  for (genvar i = 0; i < THREADS; i++) begin : g_lane
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH:0]   ea;
    logic [WIDTH:0]   eb;
    logic [WIDTH:0]   diff;
    logic [2:0]       f;

    assign a    = rs[i*WIDTH +: WIDTH];
    assign b    = rt[i*WIDTH +: WIDTH];
    // extra top bit makes the subtraction overflow-free
    assign ea   = {signed_mode & a[WIDTH-1], a};
    assign eb   = {signed_mode & b[WIDTH-1], b};
    assign diff = ea - eb;

    always_comb begin
      f = 3'b001;
      unique case (1'b1)
        (a == b):    f = 3'b010;
        diff[WIDTH]: f = 3'b100;
        default:     f = 3'b001;
      endcase
    end

    assign flags[i*3 +: 3] = f;
    assign br_taken[i] = |(nzp_q[i*3 +: 3] & br_cond);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      mask_q  <= '0;
      nzp_q   <= '0;
    end else if (accept) begin
      valid_q <= 1'b1;
      mask_q  <= thread_mask;
      for (int i = 0; i < THREADS; i++) begin
        if (thread_mask[i]) begin
          nzp_q[i*3 +: 3] <= flags[i*3 +: 3];
        end
      end
    end else if (out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign out_valid = valid_q;
  assign out_mask  = mask_q;
  assign out_nzp   = nzp_q;

endmodule

// File: tb/tb_nzp_compare_unit.sv
// Bench for nzp_compare_unit: directed scenarios plus random
// traffic against an arithmetic reference model.
module tb_nzp_compare_unit;
  localparam int W = 8;
  localparam int T = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic           in_valid;
  logic           in_ready;
  logic           signed_mode;
  logic [T-1:0]   thread_mask;
  logic [T*W-1:0] rs;
  logic [T*W-1:0] rt;
  logic           out_valid;
  logic           out_ready;
  logic [T-1:0]   out_mask;
  logic [T*3-1:0] out_nzp;
  logic [2:0]     br_cond;
  logic [T-1:0]   br_taken;

  int checks = 0;
  int errors = 0;

  logic         m_valid;
  logic [T-1:0] m_mask;
  logic [2:0]   m_nzp [T];

  nzp_compare_unit #(.WIDTH(W), .THREADS(T)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .signed_mode(signed_mode), .thread_mask(thread_mask),
    .rs(rs), .rt(rt),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_mask(out_mask), .out_nzp(out_nzp),
    .br_cond(br_cond), .br_taken(br_taken)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] ref_flag(int a, int b, bit s);
    int x;
    int y;
    x = a;
    y = b;
    if (s && a >= (1 << (W-1))) x = a - (1 << W);
    if (s && b >= (1 << (W-1))) y = b - (1 << W);
    if (x < y) return 3'b100;
    if (x == y) return 3'b010;
    return 3'b001;
  endfunction

  function automatic logic [T*3-1:0] m_packed();
    logic [T*3-1:0] p;
    for (int i = 0; i < T; i++) p[i*3 +: 3] = m_nzp[i];
    return p;
  endfunction

  function automatic logic [T-1:0] m_br();
    logic [T-1:0] r;
    for (int i = 0; i < T; i++) r[i] = |(m_nzp[i] & br_cond);
    return r;
  endfunction

  // advance one clock and move the reference model along with it
  task automatic tick();
    bit acc;
    acc = in_valid && (!m_valid || out_ready);
    @(posedge clk);
    if (reset) begin
      m_valid = 1'b0;
      m_mask  = '0;
      for (int i = 0; i < T; i++) m_nzp[i] = 3'b000;
    end else if (acc) begin
      m_valid = 1'b1;
      m_mask  = thread_mask;
      for (int i = 0; i < T; i++)
        if (thread_mask[i])
          m_nzp[i] = ref_flag(int'(rs[i*W +: W]),
                              int'(rt[i*W +: W]), signed_mode);
    end else if (out_ready) begin
      m_valid = 1'b0;
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    in_valid = 1'b1;
    thread_mask = '1;
    rs = {T*W{1'b1}};
    rt = '0;
    tick();
    tick();
    reset = 1'b0;
    in_valid = 1'b0;
    br_cond = 3'b111;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_mask !== '0 || out_nzp !== '0) begin
      errors++;
      $display("FAIL reset_state got v=%b m=%h nzp=%h want 0 0 0",
               out_valid, out_mask, out_nzp);
    end
    checks++;
    if (br_taken !== '0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_br got br=%b rdy=%b want 0 1",
               br_taken, in_ready);
    end
  endtask

  task automatic test_modes();
    out_ready = 1'b1;
    thread_mask = 4'b1111;
    rs = {8'h7F, 8'h01, 8'h05, 8'h80};
    rt = {8'h80, 8'hFF, 8'h05, 8'h01};
    signed_mode = 1'b0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_nzp !== {3'b100, 3'b100, 3'b010, 3'b001} ||
        out_valid !== 1'b1) begin
      errors++;
      $display("FAIL unsigned_mode got nzp=%h v=%b want %h 1",
               out_nzp, out_valid, {3'b100, 3'b100, 3'b010, 3'b001});
    end
    signed_mode = 1'b1;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_nzp !== {3'b001, 3'b001, 3'b010, 3'b100}) begin
      errors++;
      $display("FAIL signed_mode got nzp=%h want %h",
               out_nzp, {3'b001, 3'b001, 3'b010, 3'b100});
    end
    tick();
  endtask

  task automatic test_extremes();
    thread_mask = 4'b0011;
    rs = {8'h00, 8'h00, 8'hFF, 8'h00};
    rt = {8'h00, 8'h00, 8'h00, 8'hFF};
    for (int s = 0; s < 2; s++) begin
      signed_mode = s[0];
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      checks++;
      if (out_nzp[5:0] !== (s == 0 ? {3'b001, 3'b100}
                                   : {3'b100, 3'b001})) begin
        errors++;
        $display("FAIL extremes s=%0d got %b", s, out_nzp[5:0]);
      end
    end
    tick();
  endtask

  task automatic test_masking();
    logic [T*3-1:0] held;
    signed_mode = 1'b0;
    thread_mask = 4'b1111;
    rs = {T{8'h33}};
    rt = {T{8'h33}};
    in_valid = 1'b1;
    tick();
    thread_mask = 4'b0101;
    rs = {T{8'h01}};
    rt = {T{8'h02}};
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_nzp !== {3'b010, 3'b100, 3'b010, 3'b100} ||
        out_mask !== 4'b0101) begin
      errors++;
      $display("FAIL mask_0101 got nzp=%h m=%b", out_nzp, out_mask);
    end
    held = out_nzp;
    tick();
    thread_mask = 4'b0000;
    rs = {T{8'h09}};
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_nzp !== held || out_mask !== '0) begin
      errors++;
      $display("FAIL mask_zero got v=%b nzp=%h m=%b want 1 %h 0",
               out_valid, out_nzp, out_mask, held);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL mask_zero_pulse got v=%b want 0", out_valid);
    end
  endtask

  task automatic test_backpressure();
    signed_mode = 1'b0;
    out_ready = 1'b0;
    thread_mask = 4'b1111;
    rs = {T{8'h02}};
    rt = {T{8'h01}};
    in_valid = 1'b1;
    tick();
    thread_mask = 4'b0011;
    rs = {T{8'h01}};
    rt = {T{8'h02}};
    #1;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL stall_ready got rdy=%b v=%b want 0 1",
               in_ready, out_valid);
    end
    tick();
    checks++;
    if (out_nzp !== {T{3'b001}} || out_mask !== 4'b1111) begin
      errors++;
      $display("FAIL stall_hold got nzp=%h m=%b", out_nzp, out_mask);
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL drain_ready got %b want 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_mask !== 4'b0011 ||
        out_nzp !== {3'b001, 3'b001, 3'b100, 3'b100}) begin
      errors++;
      $display("FAIL drain_accept got v=%b m=%b nzp=%h",
               out_valid, out_mask, out_nzp);
    end
    tick();
  endtask

  task automatic test_branch();
    logic [2:0] conds [3];
    logic [T-1:0] want [3];
    conds = '{3'b010, 3'b101, 3'b000};
    want  = '{4'b1010, 4'b0101, 4'b0000};
    signed_mode = 1'b0;
    thread_mask = 4'b1111;
    rs = {8'h04, 8'h03, 8'h07, 8'h01};
    rt = {8'h04, 8'h01, 8'h07, 8'h02};
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      br_cond = conds[k];
      #1;
      checks++;
      if (br_taken !== want[k]) begin
        errors++;
        $display("FAIL branch cond=%b got %b want %b",
                 br_cond, br_taken, want[k]);
      end
    end
    tick();
  endtask

  task automatic test_reset_stall();
    out_ready = 1'b0;
    thread_mask = 4'b1111;
    rs = {T{8'hAA}};
    rt = {T{8'h11}};
    in_valid = 1'b1;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    in_valid = 1'b0;
    br_cond = 3'b111;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_nzp !== '0 ||
        br_taken !== '0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_stall got v=%b nzp=%h br=%b rdy=%b",
               out_valid, out_nzp, br_taken, in_ready);
    end
  endtask

  task automatic test_random();
    int bad;
    bad = 0;
    for (int n = 0; n < 400; n++) begin
      in_valid    = 1'($urandom_range(0, 3) != 0);
      out_ready   = 1'($urandom_range(0, 2) != 0);
      signed_mode = 1'($urandom);
      thread_mask = T'($urandom);
      br_cond     = 3'($urandom);
      rs = {$urandom, $urandom};
      rt = {$urandom, $urandom};
      if (n % 7 == 0) rt[15:8] = rs[15:8];
      #1;
      checks++;
      if (in_ready !== (!m_valid || out_ready) ||
          br_taken !== m_br()) begin
        errors++;
        if (bad++ < 10)
          $display("FAIL rand_comb n=%0d rdy=%b br=%b want %b %b",
                   n, in_ready, br_taken,
                   (!m_valid || out_ready), m_br());
      end
      tick();
      checks++;
      if (out_valid !== m_valid || out_mask !== m_mask ||
          out_nzp !== m_packed()) begin
        errors++;
        if (bad++ < 10)
          $display("FAIL rand_state n=%0d got %b %b %h want %b %b %h",
                   n, out_valid, out_mask, out_nzp,
                   m_valid, m_mask, m_packed());
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    signed_mode = 1'b0;
    thread_mask = '0;
    rs = '0;
    rt = '0;
    br_cond = 3'b000;
    m_valid = 1'b0;
    m_mask = '0;
    for (int i = 0; i < T; i++) m_nzp[i] = 3'b000;
    test_reset();
    test_modes();
    test_extremes();
    test_masking();
    test_backpressure();
    test_branch();
    test_reset_stall();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
